// File: rtl/fp_add_arbiter.sv
// Two-port round-robin front end for a shared combinational FP32 adder.
// IEEE-754 special operands are resolved locally and never reach the adder.
module fp_add_arbiter #(
  parameter int ADD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_r,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id,
  output logic        resp_bypass,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [DATA_W-1:0] QNAN = 32'h7FC00000;

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_bypass_q, resp_bypass_d;

  logic              gnt0, gnt1, hs, hs_id;
  logic [DATA_W-1:0] hs_a, hs_b;
  logic [DATA_W:0]   spec;

  function automatic logic is_nan(input logic [DATA_W-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [DATA_W-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Returns {hit, result}; denormals count as zero, so a zero exponent passes the other operand through.
  function automatic logic [DATA_W:0] special_case(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    r = {1'b1, QNAN};
    if (is_nan(a) || is_nan(b))      r = {1'b1, QNAN};
    else if (is_inf(a) && is_inf(b)) r = (a[31] != b[31]) ? {1'b1, QNAN} : {1'b1, a};
    else if (is_inf(a))              r = {1'b1, a};
    else if (is_inf(b))              r = {1'b1, b};
    else if (a[30:23] == 8'd0)       r = {1'b1, b};
    else if (b[30:23] == 8'd0)       r = {1'b1, a};
    else                             r = {1'b0, a};
    return r;
  endfunction

  always_comb begin
    gnt0       = req0_valid && (!req1_valid || !prio_q);
    gnt1       = req1_valid && (!req0_valid || prio_q);
    req0_ready = (state_q == ST_IDLE) && gnt0;
    req1_ready = (state_q == ST_IDLE) && gnt1;
    hs         = req0_ready || req1_ready;
    hs_id      = req1_ready;
    hs_a       = hs_id ? req1_a : req0_a;
    hs_b       = hs_id ? req1_b : req0_b;
    spec       = special_case(hs_a, hs_b);

    state_d       = state_q;
    prio_d        = prio_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    resp_data_d   = resp_data_q;
    resp_bypass_d = resp_bypass_q;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          a_d    = hs_a;
          b_d    = hs_b;
          id_d   = hs_id;
          prio_d = ~hs_id;
          if (spec[DATA_W]) begin
            resp_data_d   = spec[DATA_W-1:0];
            resp_bypass_d = 1'b1;
            state_d       = ST_RESP;
          end else begin
            cnt_d   = 4'(ADD_LAT);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          resp_data_d   = add_r;
          resp_bypass_d = 1'b0;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prio_q        <= 1'b0;
      cnt_q         <= 4'd0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= 1'b0;
      resp_data_q   <= '0;
      resp_bypass_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      id_q          <= id_d;
      resp_data_q   <= resp_data_d;
      resp_bypass_q <= resp_bypass_d;
    end
  end

  assign add_a       = (state_q == ST_WAIT) ? a_q : '0;
  assign add_b       = (state_q == ST_WAIT) ? b_q : '0;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_data   = resp_data_q;
  assign resp_id     = id_q;
  assign resp_bypass = resp_bypass_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: instance 0 runs with ADD_LAT=1, instance 1 with ADD_LAT=3.
// A scoreboard per instance predicts each response from the accepted operands.
module tb_fp_add_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic        byp;
  } exp_t;

  logic        clk;
  logic        rst [2];
  logic        r0v [2], r1v [2], r0r [2], r1r [2];
  logic [31:0] r0a [2], r0b [2], r1a [2], r1b [2];
  logic [31:0] add_a [2], add_b [2], add_r [2];
  logic        resp_valid [2], resp_ready [2], resp_id [2], resp_bypass [2], busy [2];
  logic [31:0] resp_data [2];

  int tests;
  int fails;
  exp_t sbq0 [$];
  exp_t sbq1 [$];

  // Stand-in for the shared adder: exact for the documented vector, otherwise an arbitrary mix.
  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40600000 && b == 32'h40400000) return 32'h40D00000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b, input logic id);
    exp_t e;
    logic an, bn, ai, bi;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    e.id  = id;
    e.byp = 1'b1;
    if (an || bn)               e.data = 32'h7FC00000;
    else if (ai && bi)          e.data = (a[31] != b[31]) ? 32'h7FC00000 : a;
    else if (ai)                e.data = a;
    else if (bi)                e.data = b;
    else if (a[30:23] == 8'd0)  e.data = b;
    else if (b[30:23] == 8'd0)  e.data = a;
    else begin
      e.data = adder_model(a, b);
      e.byp  = 1'b0;
    end
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fp_add_arbiter #(.ADD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req0_valid (r0v[g]),
      .req0_ready (r0r[g]),
      .req0_a     (r0a[g]),
      .req0_b     (r0b[g]),
      .req1_valid (r1v[g]),
      .req1_ready (r1r[g]),
      .req1_a     (r1a[g]),
      .req1_b     (r1b[g]),
      .add_a      (add_a[g]),
      .add_b      (add_b[g]),
      .add_r      (add_r[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .resp_id    (resp_id[g]),
      .resp_bypass(resp_bypass[g]),
      .busy       (busy[g])
    );
    assign add_r[g] = adder_model(add_a[g], add_b[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  task automatic monitor(input int d);
    exp_t e;
    logic nonempty;
    forever begin
      @(negedge clk);
      if (rst[d]) begin
        if (d == 0) sbq0.delete();
        else        sbq1.delete();
      end else begin
        if (r0v[d] && r0r[d]) push_exp(d, ref_op(r0a[d], r0b[d], 1'b0));
        if (r1v[d] && r1r[d]) push_exp(d, ref_op(r1a[d], r1b[d], 1'b1));
        if (resp_valid[d] && resp_ready[d]) begin
          nonempty = (d == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
          chk("sb_pending", nonempty, 1'b1);
          if (nonempty) begin
            if (d == 0) e = sbq0.pop_front();
            else        e = sbq1.pop_front();
            chk("sb_data", resp_data[d], e.data);
            chk("sb_id", resp_id[d], e.id);
            chk("sb_bypass", resp_bypass[d], e.byp);
          end
        end
      end
    end
  endtask

  task automatic set_req(input int d, input int p, input logic v,
                         input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin r0v[d] = v; r0a[d] = a; r0b[d] = b; end
    else        begin r1v[d] = v; r1a[d] = a; r1b[d] = b; end
  endtask

  task automatic do_reset(input int d);
    @(posedge clk); #1;
    rst[d] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst[d] = 1'b0;
  endtask

  task automatic wait_ready(input int d, input int p);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((p == 0 && r0r[d]) || (p == 1 && r1r[d])) begin ok = 1'b1; break; end
    end
    chk("grant_timeout", ok, 1'b1);
  endtask

  task automatic wait_any(input int d);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (r0r[d] || r1r[d]) begin ok = 1'b1; break; end
    end
    chk("any_grant_timeout", ok, 1'b1);
  endtask

  task automatic wait_resp(input int d);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid[d]) begin ok = 1'b1; break; end
    end
    chk("resp_timeout", ok, 1'b1);
  endtask

  task automatic run_op(input int d, input int p, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output logic byp);
    @(posedge clk); #1;
    set_req(d, p, 1'b1, a, b);
    wait_ready(d, p);
    @(posedge clk); #1;
    set_req(d, p, 1'b0, a, b);
    wait_resp(d);
    data = resp_data[d];
    byp  = resp_bypass[d];
  endtask

  task automatic chk_cleared(input int d);
    chk("clr_resp_valid", resp_valid[d], 1'b0);
    chk("clr_resp_data", resp_data[d], 32'h0);
    chk("clr_resp_id", resp_id[d], 1'b0);
    chk("clr_resp_bypass", resp_bypass[d], 1'b0);
    chk("clr_add_a", add_a[d], 32'h0);
    chk("clr_add_b", add_b[d], 32'h0);
    chk("clr_busy", busy[d], 1'b0);
    chk("clr_ready0", r0r[d], 1'b0);
    chk("clr_ready1", r1r[d], 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        rb;
    tests = 0;
    fails = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      resp_ready[d] = 1'b1;
      set_req(d, 0, 1'b0, 32'h0, 32'h0);
      set_req(d, 1, 1'b0, 32'h0, 32'h0);
    end
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset state
    do_reset(0);
    @(negedge clk);
    chk_cleared(0);

    // Test 1: single add through the adder, ADD_LAT=1
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 32'h40600000, 32'h40400000);
    @(negedge clk);
    chk("t1_ready0", r0r[0], 1'b1);
    chk("t1_ready1", r1r[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_wait_add_a", add_a[0], 32'h40600000);
    chk("t1_wait_add_b", add_b[0], 32'h40400000);
    chk("t1_wait_ready0", r0r[0], 1'b0);
    chk("t1_wait_busy", busy[0], 1'b1);
    chk("t1_wait_resp_valid", resp_valid[0], 1'b0);
    @(posedge clk); #1;
    set_req(0, 0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_resp_valid", resp_valid[0], 1'b1);
    chk("t1_resp_data", resp_data[0], 32'h40D00000);
    chk("t1_resp_id", resp_id[0], 1'b0);
    chk("t1_resp_bypass", resp_bypass[0], 1'b0);
    chk("t1_resp_add_a", add_a[0], 32'h0);

    // Test 2: fairness from reset with both requesters always valid
    do_reset(0);
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 32'h40600000, 32'h40400000);
    set_req(0, 1, 1'b1, 32'h3FC00000, 32'h3F800000);
    for (int i = 0; i < 4; i++) begin
      wait_any(0);
      chk("t2_ready0", r0r[0], (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("t2_ready1", r1r[0], (i % 2 == 1) ? 1'b1 : 1'b0);
      @(posedge clk);
      if (i == 3) begin
        #1;
        set_req(0, 0, 1'b0, 32'h0, 32'h0);
        set_req(0, 1, 1'b0, 32'h0, 32'h0);
      end
    end
    wait_resp(0);
    chk("t2_last_id", resp_id[0], 1'b1);

    // Test 3: zero operand bypasses the adder
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 32'h00000000, 32'hC0400000);
    wait_ready(0, 0);
    chk("t3_hs_add_a", add_a[0], 32'h0);
    @(posedge clk); #1;
    set_req(0, 0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t3_resp_valid", resp_valid[0], 1'b1);
    chk("t3_resp_data", resp_data[0], 32'hC0400000);
    chk("t3_resp_bypass", resp_bypass[0], 1'b1);
    chk("t3_add_a", add_a[0], 32'h0);
    chk("t3_add_b", add_b[0], 32'h0);

    // Test 4: infinities and NaN
    run_op(0, 1, 32'h7F800000, 32'hFF800000, rd, rb);
    chk("t4_inf_minus_inf", rd, 32'h7FC00000);
    chk("t4_inf_minus_inf_byp", rb, 1'b1);
    run_op(0, 1, 32'h7FC00001, 32'h3F800000, rd, rb);
    chk("t4_nan_in", rd, 32'h7FC00000);
    chk("t4_nan_in_byp", rb, 1'b1);
    run_op(0, 1, 32'h7F800000, 32'h3F800000, rd, rb);
    chk("t4_inf_plus_one", rd, 32'h7F800000);
    chk("t4_inf_plus_one_byp", rb, 1'b1);

    // Test 5: response backpressure with both requesters waiting
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    set_req(0, 0, 1'b1, 32'h3F800000, 32'h00000000);
    set_req(0, 1, 1'b1, 32'h00000000, 32'h40000000);
    wait_resp(0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("t5_hold_valid", resp_valid[0], 1'b1);
      chk("t5_hold_data", resp_data[0], 32'h3F800000);
      chk("t5_hold_id", resp_id[0], 1'b0);
      chk("t5_hold_ready0", r0r[0], 1'b0);
      chk("t5_hold_ready1", r1r[0], 1'b0);
      chk("t5_hold_busy", busy[0], 1'b1);
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_idle_busy", busy[0], 1'b0);
    chk("t5_idle_resp_valid", resp_valid[0], 1'b0);
    chk("t5_idle_ready1", r1r[0], 1'b1);
    chk("t5_idle_ready0", r0r[0], 1'b0);
    @(posedge clk); #1;
    set_req(0, 0, 1'b0, 32'h0, 32'h0);
    set_req(0, 1, 1'b0, 32'h0, 32'h0);
    wait_resp(0);
    chk("t5_second_id", resp_id[0], 1'b1);

    // Test 6: reset in the middle of WAIT, ADD_LAT=3
    do_reset(1);
    @(posedge clk); #1;
    set_req(1, 0, 1'b1, 32'h3F800000, 32'h40000000);
    wait_ready(1, 0);
    @(posedge clk); #1;
    set_req(1, 0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t6_wait_busy", busy[1], 1'b1);
    chk("t6_wait_add_a", add_a[1], 32'h3F800000);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk_cleared(1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t6_no_resp", resp_valid[1], 1'b0);
    end
    @(posedge clk); #1;
    set_req(1, 0, 1'b1, 32'h3F800000, 32'h00000000);
    set_req(1, 1, 1'b1, 32'h40400000, 32'h3F800000);
    @(negedge clk);
    chk("t6_prio_ready0", r0r[1], 1'b1);
    chk("t6_prio_ready1", r1r[1], 1'b0);
    @(posedge clk); #1;
    set_req(1, 0, 1'b0, 32'h0, 32'h0);
    wait_ready(1, 1);
    @(posedge clk); #1;
    set_req(1, 1, 1'b0, 32'h0, 32'h0);
    wait_resp(1);
    chk("t6_req1_id", resp_id[1], 1'b1);
    chk("t6_req1_data", resp_data[1], adder_model(32'h40400000, 32'h3F800000));

    repeat (3) @(negedge clk);
    chk("sb0_drained", sbq0.size(), 32'd0);
    chk("sb1_drained", sbq1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
